seq_adder: RTL and testbench
============================

# seq_adder

Parametrised multi-cycle adder built from a DIGIT-bit full-adder slice that is reused every clock. It adds two WIDTH-bit operands plus a carry-in, least-significant digit first, and returns the sum and carry-out. The block is the sequential successor to the single-bit full adder in the lab datapath. It trades latency for area and gives later labs a start/done handshake to drive from an FSM.

## Interface
- WIDTH, 8: operand and sum width in bits; must be ≥ 2.
- DIGIT, 1: bits added per cycle; must divide WIDTH exactly. K = WIDTH/DIGIT is the number of compute cycles.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready = 1.
- A  in  WIDTH  operand A; sampled on the accepting edge.
- B  in  WIDTH  operand B; sampled on the accepting edge.
- Cin  in  1  carry-in; sampled on the accepting edge.
- ready  out  1  high in IDLE; the block accepts start.
- Sum  out  WIDTH  result register.
- Cout  out  1  final carry-out register.
- done  out  1  one-cycle pulse; Sum and Cout are valid.
- Ovf  out  1  signed overflow; present only with SEQ_ADDER_OVF_EN.

## Operation
- FSM states:
  - IDLE → RUN when start is high on a clock edge.
  - RUN → RUN while the digit counter is below K-1.
  - RUN → DONE on the edge that processes digit K-1.
  - DONE → IDLE unconditionally.
- Accepting edge:
  - A and B are latched into shift registers.
  - Cin is latched into the carry flop.
  - The digit counter is cleared to 0.
  - Sum is cleared to 0.
- Each RUN edge:
  - Adds the low DIGIT bits of the A and B shift registers plus the carry flop.
  - Writes the DIGIT-bit result into Sum bits [i*DIGIT +: DIGIT], where i is the digit counter.
  - Updates the carry flop, shifts both operand registers right by DIGIT, and increments the counter.
- Arithmetic: {Cout, Sum} = A + B + Cin exactly, as unsigned (WIDTH+1) bits; no truncation other than Cout.
- Cout is loaded from the carry flop on the RUN→DONE edge.
- Counter width is $clog2(K), minimum 1 bit. The counter never wraps in normal operation; the RUN→DONE decision is taken at the value K-1.
- start while not in IDLE is ignored; no queuing and no error flag.
- Sum, Cout and Ovf hold their value from DONE until the next accepting edge.
- A, B and Cin may change freely after the accepting edge without affecting the result.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - State = IDLE, ready = 1, done = 0.
  - Sum = 0, Cout = 0, Ovf = 0.
  - Counter, carry flop and shift registers = 0.
- Latency:
  - Accepting edge t0.
  - Digits are computed on edges t0+1 … t0+K.
  - done = 1 and the outputs are valid during the cycle after edge t0+K.
  - ready returns to 1 after edge t0+K+1.
- Throughput: one addition per K+2 cycles. start may be held high continuously; it is accepted again on the first edge where ready = 1.
- ready = 0 in RUN and DONE; ready and done are never high together.
- Reset asserted mid-operation aborts the addition immediately. No done pulse is produced. The next start after rst_n rises is processed normally.
- DIGIT = WIDTH (K = 1) is legal: exactly one RUN cycle.

## Configuration
- SEQ_ADDER_OVF_EN defined:
  - Ovf is a port and a register.
  - On the RUN→DONE edge it loads the two's-complement overflow: operand MSBs equal and Sum MSB different.
  - The MSBs are captured from A and B on the accepting edge.
  - Ovf resets to 0 and holds like Sum.
- SEQ_ADDER_OVF_EN undefined: the Ovf port and its logic do not exist; all other behaviour is identical.

## Test plan
- WIDTH=8, DIGIT=1: A=0xFF, B=0x01, Cin=0 → Sum=0x00, Cout=1, done exactly 8 cycles after the accepting edge, ready back one cycle later.
- WIDTH=8, DIGIT=4: A=0xA5, B=0x5A, Cin=1 → Sum=0x00, Cout=1, done 2 cycles after acceptance.
- With SEQ_ADDER_OVF_EN, WIDTH=8:
  - 0x7F+0x01, Cin=0 → Sum=0x80, Ovf=1, Cout=0.
  - 0x80+0x80 → Sum=0x00, Ovf=1, Cout=1.
  - 0x01+0x01 → Ovf=0.
- Pulse start on the 3rd RUN cycle with different operands → ignored; result matches the first operands; exactly one done pulse.
- Assert rst_n=0 mid-RUN → all outputs 0 and ready=1 immediately. Then 0x12+0x34 → Sum=0x46, Cout=0, with no spurious done.
- WIDTH=4, DIGIT=1 and DIGIT=2: all 512 combinations of A, B, Cin with start held high → every {Cout, Sum} equals A+B+Cin, and done is spaced exactly K+2 cycles apart.

Source files
------------

// File: rtl/seq_adder.sv
// seq_adder: digit-serial adder computing {Cout,Sum} = A+B+Cin, DIGIT bits per clock, with start/ready/done handshake.
// Define SEQ_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             done
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int K = WIDTH / DIGIT;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic carry;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] dsum;
  logic last;
`ifdef SEQ_ADDER_OVF_EN
  logic msb_a, msb_b;
`endif
  always_comb begin
    dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    last = cnt == CW'(K - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SEQ_ADDER_OVF_EN
      Ovf   <= 1'b0;
      msb_a <= 1'b0;
      msb_b <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          ready <= 1'b0;
          a_sh  <= A;
          b_sh  <= B;
          carry <= Cin;
          cnt   <= '0;
          Sum   <= '0;
`ifdef SEQ_ADDER_OVF_EN
          msb_a <= A[WIDTH-1];
          msb_b <= B[WIDTH-1];
`endif
        end
        RUN: begin
          Sum[cnt*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
          carry <= dsum[DIGIT];
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          // the final digit's carry and sum MSB are taken straight from the slice
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
            Cout  <= dsum[DIGIT];
`ifdef SEQ_ADDER_OVF_EN
            Ovf   <= (msb_a == msb_b) && (dsum[DIGIT-1] != msb_a);
`endif
          end else cnt <= cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: checks four seq_adder configurations against a cycle-counting arithmetic model plus directed literals.
module tb_seq_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [3:0] st, ci, rdy, dn, co, ov;
  logic [7:0] a [4];
  logic [7:0] b [4];
  logic [7:0] sm [4];
  int n_tests = 0, n_fail = 0;
  bit busy [4];
  int m [4];
  int exp_v [4];
  bit exp_o [4];
  int dcount [4];
  int lat, d0;
  logic [7:0] rs;
  logic rc, ro;

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int W = g < 2 ? 8 : 4;
    localparam int D = (g == 1) ? 4 : (g == 3) ? 2 : 1;
    logic [W-1:0] s;
    logic o;
    seq_adder #(.WIDTH(W), .DIGIT(D)) u (
      .clk(clk), .rst_n(rst_n), .start(st[g]), .A(a[g][W-1:0]), .B(b[g][W-1:0]),
      .Cin(ci[g]), .ready(rdy[g]), .Sum(s), .Cout(co[g]), .done(dn[g])
`ifdef SEQ_ADDER_OVF_EN
      , .Ovf(o)
`endif
    );
`ifndef SEQ_ADDER_OVF_EN
    assign o = 1'b0;
`endif
    assign sm[g] = 8'(s);
    assign ov[g] = o;
  end

  function automatic int w_of(int i);
    return i < 2 ? 8 : 4;
  endfunction
  function automatic int k_of(int i);
    return i == 0 ? 8 : i == 2 ? 4 : 2;
  endfunction
  function automatic bit ovf_of(int w, int av, int bv, int cv);
    int sa = av >= (1 << (w - 1)) ? av - (1 << w) : av;
    int sb = bv >= (1 << (w - 1)) ? bv - (1 << w) : bv;
    int s = sa + sb + cv;
    return s > (1 << (w - 1)) - 1 || s < -(1 << (w - 1));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // model: an accepted request completes K edges later; the block is busy for K+1 edges
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) busy[i] = 1'b0;
      else if (busy[i]) begin
        m[i]++;
        if (m[i] == k_of(i) + 1) busy[i] = 1'b0;
      end else if (st[i]) begin
        busy[i] = 1'b1;
        m[i] = 0;
        exp_v[i] = (int'(a[i]) & ((1 << w_of(i)) - 1)) + (int'(b[i]) & ((1 << w_of(i)) - 1)) + int'(ci[i]);
        exp_o[i] = ovf_of(w_of(i), int'(a[i]) & ((1 << w_of(i)) - 1), int'(b[i]) & ((1 << w_of(i)) - 1), int'(ci[i]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ready[%0d]", i), int'(rdy[i]), int'(!busy[i]));
        chk($sformatf("done[%0d]", i), int'(dn[i]), int'(busy[i] && m[i] == k_of(i)));
        if (dn[i]) dcount[i]++;
        if (busy[i] && m[i] == k_of(i)) begin
          chk($sformatf("sum[%0d]", i), int'(sm[i]), exp_v[i] & ((1 << w_of(i)) - 1));
          chk($sformatf("cout[%0d]", i), int'(co[i]), (exp_v[i] >> w_of(i)) & 1);
`ifdef SEQ_ADDER_OVF_EN
          chk($sformatf("ovf[%0d]", i), int'(ov[i]), int'(exp_o[i]));
`endif
        end
      end
    end
  end

  // called at a falling edge; returns edges from acceptance to done and the outputs seen with done
  task automatic xact(input int i, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input int pulse_at, output int l, output logic [7:0] s, output logic c, output logic o);
    int n;
    n = 0;
    while (!rdy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) chk("ready_timeout", 0, 1);
    a[i] = av;
    b[i] = bv;
    ci[i] = cv;
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    a[i] = ~av;
    b[i] = ~bv;
    ci[i] = ~cv;
    l = 0;
    while (!dn[i] && l < 50) begin
      if (l == pulse_at) begin
        st[i] = 1'b1;
        a[i] = 8'h55;
        b[i] = 8'h66;
      end
      @(negedge clk);
      st[i] = 1'b0;
      l++;
    end
    if (!dn[i]) chk("done_timeout", 0, 1);
    s = sm[i];
    c = co[i];
    o = ov[i];
  endtask

  task automatic directed(input string nm, input int i, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input int pulse_at, input int es, input int ec, input int eo);
    int l, dc;
    logic [7:0] s;
    logic c, o;
    dc = dcount[i];
    xact(i, av, bv, cv, pulse_at, l, s, c, o);
    chk({nm, "_lat"}, l, k_of(i));
    chk({nm, "_sum"}, int'(s), es);
    chk({nm, "_cout"}, int'(c), ec);
`ifdef SEQ_ADDER_OVF_EN
    chk({nm, "_ovf"}, int'(o), eo);
`else
    if (eo < 0) chk({nm, "_ovf"}, int'(o), 0);
`endif
    @(negedge clk);
    chk({nm, "_ready_back"}, int'(rdy[i]), 1);
    chk({nm, "_one_done"}, dcount[i] - dc, 1);
  endtask

  task automatic sweep(input int i);
    int n, dc;
    dc = dcount[i];
    for (int v = 0; v < 512; v++) begin
      n = 0;
      while (!rdy[i] && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!rdy[i]) begin
        chk("sweep_ready_timeout", 0, 1);
        break;
      end
      a[i] = {4'h0, v[3:0]};
      b[i] = {4'h0, v[7:4]};
      ci[i] = v[8];
      st[i] = 1'b1;
      @(negedge clk);
    end
    st[i] = 1'b0;
    repeat (k_of(i) + 2) @(negedge clk);
    chk($sformatf("sweep_done_count[%0d]", i), dcount[i] - dc, 512);
  endtask

  initial begin
    st = '0;
    ci = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      b[i] = '0;
      m[i] = 0;
      dcount[i] = 0;
    end
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_ready[%0d]", i), int'(rdy[i]), 1);
      chk($sformatf("rst_done[%0d]", i), int'(dn[i]), 0);
      chk($sformatf("rst_sum[%0d]", i), int'(sm[i]), 0);
      chk($sformatf("rst_cout[%0d]", i), int'(co[i]), 0);
      chk($sformatf("rst_ovf[%0d]", i), int'(ov[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    directed("ff_01", 0, 8'hFF, 8'h01, 1'b0, -1, 8'h00, 1, 0);
    directed("a5_5a_d4", 1, 8'hA5, 8'h5A, 1'b1, -1, 8'h00, 1, 0);
    directed("7f_01", 0, 8'h7F, 8'h01, 1'b0, -1, 8'h80, 0, 1);
    directed("80_80", 0, 8'h80, 8'h80, 1'b0, -1, 8'h00, 1, 1);
    directed("01_01", 0, 8'h01, 8'h01, 1'b0, -1, 8'h02, 0, 0);
    directed("7f_01_d4", 1, 8'h7F, 8'h01, 1'b0, -1, 8'h80, 0, 1);
    directed("start_in_run", 0, 8'h3C, 8'h0F, 1'b0, 2, 8'h4B, 0, 0);
    // abort a run part-way: after two RUN edges Sum holds 0x03
    d0 = dcount[0];
    a[0] = 8'hAA;
    b[0] = 8'h55;
    ci[0] = 1'b0;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_run_sum", int'(sm[0]), 8'h03);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ready", int'(rdy[0]), 1);
    chk("abort_done", int'(dn[0]), 0);
    chk("abort_sum", int'(sm[0]), 0);
    chk("abort_cout", int'(co[0]), 0);
    chk("abort_ovf", int'(ov[0]), 0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    directed("12_34", 0, 8'h12, 8'h34, 1'b0, -1, 8'h46, 0, 0);
    chk("abort_no_done", dcount[0] - d0, 1);
    fork
      sweep(2);
      sweep(3);
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
